aes_subbytes_iter: RTL and testbench

AES_SUBBYTES_ITER -- requirements
Module: aes_subbytes_iter

---
 rtl/aes_subbytes_iter.sv | 191 +++++++++++++++++++
 tb/tb_aes_subbytes_iter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_iter.sv
// rtl/aes_subbytes_iter.sv - iterative AES (Inv)SubBytes over LANES registered S-box lookups per cycle
package aes_sbox_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

endpackage

module aes_sbox_bram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= 8'h00;
        else        dout <= aes_sbox_pkg::sbox_fwd(addr);
    end
endmodule

module aes_inv_sbox_bram (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= 8'h00;
        else        dout <= aes_sbox_pkg::sbox_inv(addr);
    end
endmodule

module aes_subbytes_iter #(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int BEATS  = 16 / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat, wr_beat;
    logic              wr_en;
    logic              mode;
    logic [127:0]      blk;
    logic [127:0]      result;
    logic [7:0]        lane_addr [LANES];
    logic [7:0]        fwd_dout  [LANES];
    logic [7:0]        inv_dout  [LANES];
    logic              accept;
    logic              last_beat;

    assign accept    = (state == IDLE) && in_valid;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign state_out = result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN:   if (last_beat) state_nxt = DRAIN;
            DRAIN: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane data lands one cycle after issue, so the write side replays the issuing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            wr_beat <= '0;
            wr_en   <= 1'b0;
            mode    <= 1'b0;
            blk     <= 128'h0;
            result  <= 128'h0;
        end else begin
            wr_en   <= (state == RUN);
            wr_beat <= beat;
            if (accept) begin
                blk  <= state_in;
                mode <= inv & INV_EN;
                beat <= '0;
            end else if (state == RUN) begin
                beat <= beat + 1'b1;
            end
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) begin
                    result[127 - 8 * (int'(wr_beat) * LANES + l) -: 8] <= mode ? inv_dout[l] : fwd_dout[l];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_addr[l] = 8'h00;
            if (state == RUN) lane_addr[l] = blk[127 - 8 * (int'(beat) * LANES + l) -: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_bram u_fwd (
            .clk   (clk),
            .rst_n (rst_n),
            .addr  (lane_addr[l]),
            .dout  (fwd_dout[l])
        );
        if (INV_EN) begin : g_inv
            aes_inv_sbox_bram u_inv (
                .clk   (clk),
                .rst_n (rst_n),
                .addr  (lane_addr[l]),
                .dout  (inv_dout[l])
            );
        end else begin : g_no_inv
            assign inv_dout[l] = 8'h00;
        end
    end

endmodule

// File: tb/tb_aes_subbytes_iter.sv
// tb/tb_aes_subbytes_iter.sv - scoreboard bench for aes_subbytes_iter
module tb_aes_subbytes_iter;

    localparam int AUX_N = 5;
    localparam int AUX_LAT [AUX_N] = '{17, 9, 3, 2, 5};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] state_in = 128'h0;
    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;

    logic         aux_iv = 1'b0;
    logic         aux_inv = 1'b0;
    logic         aux_or = 1'b0;
    logic [127:0] aux_in = 128'h0;
    logic         aux_ir   [AUX_N];
    logic         aux_ov   [AUX_N];
    logic         aux_busy [AUX_N];
    logic [127:0] aux_so   [AUX_N];

    typedef struct {
        logic [127:0] st;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [7:0]   sbox_t [256];
    logic [7:0]   isbox_t [256];
    logic [2047:0] sbox_flat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_subbytes_iter #(.LANES(4), .INV_EN(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    for (genvar g = 0; g < AUX_N; g++) begin : g_aux
        localparam int L  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : (g == 3) ? 16 : 4;
        localparam bit IE = (g != 4);
        aes_subbytes_iter #(.LANES(L), .INV_EN(IE)) u_aux (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (aux_iv),
            .in_ready  (aux_ir[g]),
            .state_in  (aux_in),
            .inv       (aux_inv),
            .out_valid (aux_ov[g]),
            .out_ready (aux_or),
            .state_out (aux_so[g]),
            .busy      (aux_busy[g])
        );
    end

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per delivered block, then checks the output holds while waiting.
    logic         seen = 1'b0;
    logic [127:0] held = 128'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 128'(out_valid), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("state_out", state_out, e.st);
                chk("latency", 128'(cyc - e.acc), 128'(5));
            end
            seen = 1'b1;
            held = state_out;
        end else if (out_valid && seen) begin
            chk("hold_stable", state_out, held);
        end else begin
            seen = 1'b0;
        end
    end

    task automatic send(input logic [127:0] st, input logic iv, input logic [127:0] exp, output int acc);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        state_in = st;
        inv      = iv;
        acc      = cyc + 1;
        e.st     = exp;
        e.acc    = acc;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        state_in = ~st;
        inv      = ~iv;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic aux_run(input logic [127:0] st, input logic iv, input logic [127:0] exp, input logic [127:0] e4);
        logic [AUX_N-1:0] done;
        int acc;
        @(negedge clk);
        for (int g = 0; g < AUX_N; g++) chk($sformatf("aux%0d_in_ready", g), 128'(aux_ir[g]), 128'(1));
        aux_iv  = 1'b1;
        aux_in  = st;
        aux_inv = iv;
        acc     = cyc + 1;
        @(negedge clk);
        aux_iv  = 1'b0;
        aux_in  = ~st;
        aux_inv = ~iv;
        for (int g = 0; g < AUX_N; g++) chk($sformatf("aux%0d_busy", g), 128'(aux_busy[g]), 128'(1));
        done = '0;
        for (int n = 0; n < 40 && done != '1; n++) begin
            for (int g = 0; g < AUX_N; g++) begin
                if (!done[g] && aux_ov[g]) begin
                    chk($sformatf("aux%0d_state", g), aux_so[g], (g == 4) ? e4 : exp);
                    chk($sformatf("aux%0d_latency", g), 128'(cyc - acc), 128'(AUX_LAT[g]));
                    done[g] = 1'b1;
                end
            end
            if (done != '1) @(negedge clk);
        end
        for (int g = 0; g < AUX_N; g++) if (!done[g]) chk($sformatf("aux%0d_timeout", g), 128'(0), 128'(1));
        aux_or = 1'b1;
        @(negedge clk);
        aux_or = 1'b0;
        for (int g = 0; g < AUX_N; g++) chk($sformatf("aux%0d_ov_fall", g), 128'(aux_ov[g]), 128'(0));
    endtask

    initial begin
        int a1, a2, n;
        logic [127:0] st, ex;
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) begin
            sbox_t[i] = sbox_flat[2047 - 8 * i -: 8];
            isbox_t[sbox_t[i]] = 8'(i);
        end

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_state_out", state_out, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        send(128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, a1);
        send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, a1);
        send({16{8'h53}}, 1'b0, {16{8'hed}}, a1);
        send({16{8'hed}}, 1'b1, {16{8'h53}}, a1);
        wait_idle();

        send({16{8'h00}}, 1'b0, {16{8'h63}}, a1);
        send({16{8'hff}}, 1'b0, {16{8'h16}}, a2);
        chk("throughput", 128'(a2 - a1), 128'(7));
        wait_idle();

        out_ready = 1'b0;
        send(128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, a1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", 128'(out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = i[0];
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", 128'(out_valid), 128'(0));
        chk("release_busy", 128'(busy), 128'(0));
        chk("release_in_ready", 128'(in_ready), 128'(1));

        in_valid = 1'b1;
        state_in = {16{8'h53}};
        inv      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_state_out", state_out, 128'h0);
        chk("abort_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_delivery", 128'(out_valid), 128'(0));
        send(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, a1);
        wait_idle();

        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 16; b++) begin
                for (int k = 0; k < 16; k++) begin
                    st[127 - 8 * k -: 8] = 8'(16 * b + k);
                    ex[127 - 8 * k -: 8] = (m == 0) ? sbox_t[16 * b + k] : isbox_t[16 * b + k];
                end
                send(st, m[0], ex, a1);
            end
        end
        wait_idle();

        aux_run({16{8'h53}}, 1'b0, {16{8'hed}}, {16{8'hed}});
        aux_run(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                128'h00112233445566778899aabbccddeeff, 128'hfb13dc2eafb0c3e61c289187b3783447);
        aux_run({16{8'hed}}, 1'b1, {16{8'h53}}, {16{8'h55}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
